// File: rtl/rd_stream_if.sv
// rd_stream_if: FIFO read-port and valid/ready stream signals of the read-side adapter.
interface rd_stream_if #(parameter int DATA_SIZE = 8);
    logic                 rempty;
    logic [DATA_SIZE-1:0] rdata;
    logic                 rinc;
    logic                 m_valid;
    logic                 m_ready;
    logic [DATA_SIZE-1:0] m_data;
    modport master (input rempty, rdata, m_ready, output rinc, m_valid, m_data);
    modport slave  (output rempty, rdata, m_ready, input rinc, m_valid, m_data);
endinterface

// File: rtl/rd_stream_adapter.sv
// rd_stream_adapter: 2-entry skid buffer turning a FIFO read port into a registered valid/ready stream.
// Defining RD_STREAM_STATS_EN adds xfer_cnt/stall_cnt statistics with a stat_clr input.
module rd_stream_adapter #(
    parameter int DATA_SIZE = 8
) (
    input  logic        rclk,
    input  logic        rrst_n,
    input  logic        flush,
`ifdef RD_STREAM_STATS_EN
    input  logic        stat_clr,
    output logic [15:0] xfer_cnt,
    output logic [15:0] stall_cnt,
`endif
    rd_stream_if.master bus
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t state, state_nxt;
    logic [DATA_SIZE-1:0] buf0, buf1, buf0_nxt, buf1_nxt;
    logic pop, rinc;
    assign bus.m_valid = state != EMPTY;
    assign bus.m_data  = buf0;
    assign pop  = bus.m_valid & bus.m_ready;
    // Gated by reset so the read pointer cannot advance while the adapter is held in reset.
    assign rinc = rrst_n & ~bus.rempty & ~flush & (state != FULL | pop);
    assign bus.rinc = rinc;
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state <= EMPTY;
            buf0  <= '0;
            buf1  <= '0;
        end else begin
            state <= state_nxt;
            buf0  <= buf0_nxt;
            buf1  <= buf1_nxt;
        end
    end
    always_comb begin
        state_nxt = state;
        buf0_nxt  = buf0;
        buf1_nxt  = buf1;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            unique case (state)
                EMPTY: if (rinc) begin
                    buf0_nxt  = bus.rdata;
                    state_nxt = ONE;
                end
                ONE: begin
                    buf0_nxt  = rinc & pop ? bus.rdata : buf0;
                    buf1_nxt  = rinc & ~pop ? bus.rdata : buf1;
                    state_nxt = rinc & ~pop ? FULL : pop & ~rinc ? EMPTY : ONE;
                end
                FULL: if (pop) begin
                    buf0_nxt  = buf1;
                    buf1_nxt  = rinc ? bus.rdata : buf1;
                    state_nxt = rinc ? FULL : ONE;
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end
`ifdef RD_STREAM_STATS_EN
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            xfer_cnt  <= '0;
            stall_cnt <= '0;
        end else if (stat_clr) begin
            xfer_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            xfer_cnt  <= xfer_cnt + 16'(pop);
            stall_cnt <= (bus.m_valid & ~bus.m_ready & stall_cnt != 16'hFFFF) ? stall_cnt + 16'd1 : stall_cnt;
        end
    end
`endif
endmodule

// File: tb/tb_rd_stream_adapter.sv
// tb_rd_stream_adapter: directed stimulus with a FIFO model and a scoreboard monitor on stream pops.
module tb_rd_stream_adapter;
    logic rclk = 0, rrst_n = 0, flush = 0;
    logic rinc_neg = 0;
    int   n_cmp = 0, n_bad = 0, rinc_cnt = 0;
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
`ifdef RD_STREAM_STATS_EN
    logic stat_clr = 0;
    logic [15:0] xfer_cnt, stall_cnt;
`endif
    rd_stream_if #(.DATA_SIZE(8)) bus();
    rd_stream_adapter #(.DATA_SIZE(8)) dut (
        .rclk(rclk),
        .rrst_n(rrst_n),
        .flush(flush),
`ifdef RD_STREAM_STATS_EN
        .stat_clr(stat_clr),
        .xfer_cnt(xfer_cnt),
        .stall_cnt(stall_cnt),
`endif
        .bus(bus)
    );
    always #5 rclk = ~rclk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fifo_refresh();
        bus.rempty = fifo_q.size() == 0;
        bus.rdata  = bus.rempty ? 8'h00 : fifo_q[0];
    endtask

    task automatic tick();
        @(posedge rclk);
        #3;
    endtask

    // FIFO model: the read pointer advances on an edge where rinc was high.
    always begin
        @(posedge rclk);
        if (rinc_neg && fifo_q.size() > 0) void'(fifo_q.pop_front());
        #2;
        fifo_refresh();
    end

    // Scoreboard monitor
    always @(negedge rclk) begin
        rinc_neg = bus.rinc;
        if (bus.rinc) rinc_cnt++;
        if (rrst_n && bus.m_valid && bus.m_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pop: got %h expected no transfer at %0t", bus.m_data, $time);
            end else begin
                check("pop_data", {8'h00, bus.m_data}, {8'h00, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.m_ready = 1;
        fifo_q.push_back(8'h11);
        fifo_refresh();
        #1;
        check("rst_rinc", bus.rinc, 0);
        check("rst_valid", bus.m_valid, 0);
        check("rst_data", bus.m_data, 0);
        tick(); tick();
        rrst_n = 1;
        #1;
        // REQ-034 style first word
        check("first_rinc", bus.rinc, 1);
        check("first_valid_pre", bus.m_valid, 0);
        exp_q.push_back(8'h11);
        tick();
        check("first_valid", bus.m_valid, 1);
        check("first_data", bus.m_data, 16'h11);
        check("first_rinc_after", bus.rinc, 0);
        tick();
        check("first_drained", bus.m_valid, 0);

        // Fill to FULL with backpressure, then drain at full rate
        bus.m_ready = 0;
        for (int i = 0; i < 4; i++) fifo_q.push_back(8'hA0 + 8'(i));
        fifo_refresh();
        rinc_cnt = 0;
        for (int i = 0; i < 4; i++) tick();
        check("full_rinc_pulses", 16'(rinc_cnt), 2);
        check("full_rinc", bus.rinc, 0);
        check("full_valid", bus.m_valid, 1);
        check("full_hold", bus.m_data, 16'hA0);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'hA0 + 8'(i));
        bus.m_ready = 1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", bus.m_valid, 1);
            check("drain_data", bus.m_data, 16'(8'hA0 + 8'(i)));
            tick();
        end
        check("drain_done", bus.m_valid, 0);

        // Empty FIFO: never read, never valid
        for (int i = 0; i < 12; i++) begin
            bus.m_ready = 1'($urandom_range(0, 1));
            #1;
            check("empty_rinc", bus.rinc, 0);
            check("empty_valid", bus.m_valid, 0);
            tick();
        end

        // Flush while FULL: head transfers, rest dropped, FIFO word kept
        bus.m_ready = 0;
        fifo_q.push_back(8'hB0); fifo_q.push_back(8'hB1); fifo_q.push_back(8'hB2);
        fifo_refresh();
        tick(); tick();
        check("pre_flush_full", bus.rinc, 0);
        flush = 1;
        bus.m_ready = 1;
        exp_q.push_back(8'hB0);
        #1;
        check("flush_rinc", bus.rinc, 0);
        tick();
        flush = 0;
        #1;
        check("post_flush_valid", bus.m_valid, 0);
        check("post_flush_rinc", bus.rinc, 1);
        exp_q.push_back(8'hB2);
        tick();
        check("after_flush_valid", bus.m_valid, 1);
        check("after_flush_data", bus.m_data, 16'hB2);
        tick();
        check("after_flush_empty", bus.m_valid, 0);

        // Asynchronous reset while FULL
        bus.m_ready = 0;
        fifo_q.push_back(8'hC0); fifo_q.push_back(8'hC1); fifo_q.push_back(8'hC2);
        fifo_refresh();
        tick(); tick();
        check("pre_rst_valid", bus.m_valid, 1);
        rrst_n = 0;
        #1;
        check("async_rst_valid", bus.m_valid, 0);
        check("async_rst_data", bus.m_data, 0);
        check("async_rst_rinc", bus.rinc, 0);
        tick();
        rrst_n = 1;
        bus.m_ready = 1;
        #1;
        check("rel_rinc", bus.rinc, 1);
        exp_q.push_back(8'hC2);
        tick();
        check("rel_valid", bus.m_valid, 1);
        check("rel_data", bus.m_data, 16'hC2);
        tick();
        check("rel_empty", bus.m_valid, 0);

`ifdef RD_STREAM_STATS_EN
        stat_clr = 1;
        tick();
        stat_clr = 0;
        check("clr_xfer", xfer_cnt, 0);
        check("clr_stall", stall_cnt, 0);
        bus.m_ready = 0;
        for (int i = 0; i < 5; i++) begin
            fifo_q.push_back(8'hD0 + 8'(i));
            exp_q.push_back(8'hD0 + 8'(i));
        end
        fifo_refresh();
        for (int i = 0; i < 4; i++) tick();
        bus.m_ready = 1;
        for (int i = 0; i < 6; i++) tick();
        check("stat_xfer", xfer_cnt, 5);
        check("stat_stall", stall_cnt, 3);
        stat_clr = 1;
        tick();
        stat_clr = 0;
        check("stat_clr_xfer", xfer_cnt, 0);
        check("stat_clr_stall", stall_cnt, 0);
`endif

        tick();
        check("scoreboard_empty", 16'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
